// File: rtl/serial_key_lock_if.sv
// serial_key_lock_if: the switch/button side and the LED/status side of the
// serial key lock, grouped into one bundle. The master drives the shift
// strobe and the data bit. The slave (the lock) drives the indicators and
// counters. When SERIAL_KEY_LOCK_PROGRESS_EN is defined, the bundle also
// carries match_prefix.
interface serial_key_lock_if #(
  parameter int CW = 7,
  parameter int FW = 2
);
  logic          shift;
  logic          d;
  logic          led1;
  logic          led2;
  logic [CW-1:0] bit_count;
  logic [FW-1:0] fail_count;
`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
  logic [CW-1:0] match_prefix;

  modport master (
    output shift, d,
    input  led1, led2, bit_count, fail_count, match_prefix
  );

  modport slave (
    input  shift, d,
    output led1, led2, bit_count, fail_count, match_prefix
  );
`else
  modport master (
    output shift, d,
    input  led1, led2, bit_count, fail_count
  );

  modport slave (
    input  shift, d,
    output led1, led2, bit_count, fail_count
  );
`endif
endinterface

// File: rtl/serial_key_lock.sv
// serial_key_lock: a serial key checker with a failed-attempt lockout.
//
// Bits on d are shifted in MSB-first on rising edges of the asynchronous
// shift strobe. Each framed KEY_WIDTH-bit attempt is compared against KEY.
// - A match lights led1. The lock then stays unlocked until reset.
// - Each failed attempt increments fail_count.
// - MAX_FAILS failures hold the lock shut for LOCK_CYCLES clocks, with led2
//   high for that time.
//
// shift and d are synchronised side by side through SYNC_STAGES flops, so a
// bit is always paired with the strobe it arrived with.
//
// Parameter constraints: KEY_WIDTH >= 2, SYNC_STAGES >= 2, MAX_FAILS >= 1,
// LOCK_CYCLES >= 1.
//
// Optional feature: define SERIAL_KEY_LOCK_PROGRESS_EN to add match_prefix.
// It reports how many leading bits of the current attempt agree with KEY.
module serial_key_lock #(
  parameter int                   KEY_WIDTH   = 64,
  parameter logic [KEY_WIDTH-1:0] KEY         = KEY_WIDTH'(64'h39C3_ADF0_E798_E1BC),
  parameter int                   SYNC_STAGES = 2,
  parameter int                   MAX_FAILS   = 3,
  parameter int                   LOCK_CYCLES = 1000
) (
  input logic              clk,
  input logic              reset,
  serial_key_lock_if.slave bus
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  localparam logic [CW-1:0] LAST_BIT  = CW'(KEY_WIDTH - 1);
  localparam logic [FW-1:0] FAILS_MAX = FW'(MAX_FAILS);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES);
  localparam logic [TW-1:0] LOCK_LAST = TW'(1);

  typedef enum logic [1:0] {
    SHIFTING = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] shift_sync_q;
  logic [SYNC_STAGES-1:0] d_sync_q;
  logic                   shift_prev_q;
  logic                   shift_sync;
  logic                   d_sync;
  logic                   shift_edge;

  state_t                 state;
  logic [KEY_WIDTH-1:0]   sr;
  logic [CW-1:0]          bit_cnt;
  logic [FW-1:0]          fail_cnt;
  logic [TW-1:0]          lock_timer;
  logic                   led1_q;
  logic                   led2_q;

`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
  logic [CW-1:0]          prefix;
  logic [KEY_WIDTH-1:0]   key_aligned;
  logic                   key_bit;

  // The key bit expected next is at index KEY_WIDTH-1-bit_cnt. Shifting the
  // key left by bit_cnt moves that bit to the top, which avoids a
  // variable-index select.
  assign key_aligned = KEY << bit_cnt;
  assign key_bit     = key_aligned[KEY_WIDTH-1];
`endif

  // Synchroniser: shift and d move through parallel flop chains, so both
  // leave on the same cycle. shift_prev is one more flop on the shift chain
  // and is used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_sync_q <= '0;
      d_sync_q     <= '0;
      shift_prev_q <= 1'b0;
    end else begin
      shift_sync_q <= {shift_sync_q[SYNC_STAGES-2:0], bus.shift};
      d_sync_q     <= {d_sync_q[SYNC_STAGES-2:0], bus.d};
      shift_prev_q <= shift_sync;
    end
  end

  // ---- synchronised domain: rising-edge detect, falling edges ignored ----
  assign shift_sync = shift_sync_q[SYNC_STAGES-1];
  assign d_sync     = d_sync_q[SYNC_STAGES-1];
  assign shift_edge = shift_sync & ~shift_prev_q;

  // Attempt FSM: owns the shift register, counters and lock timer. The LEDs
  // are registered next to the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SHIFTING;
      sr         <= '0;
      bit_cnt    <= '0;
      fail_cnt   <= '0;
      lock_timer <= '0;
      led1_q     <= 1'b0;
      led2_q     <= 1'b0;
`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
      prefix     <= '0;
`endif
    end else begin
      case (state)
        SHIFTING: begin
          if (shift_edge) begin
            sr      <= {sr[KEY_WIDTH-2:0], d_sync};
            bit_cnt <= bit_cnt + 1'b1;
`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
            // The prefix grows only while every bit so far has matched.
            // After the first mismatch it stays frozen.
            if ((prefix == bit_cnt) && (d_sync == key_bit)) begin
              prefix <= prefix + 1'b1;
            end
`endif
            // The edge that delivers the last bit closes the frame.
            if (bit_cnt == LAST_BIT) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          // Edges seen in this cycle are dropped on purpose.
          if (sr == KEY) begin
            state  <= UNLOCKED;
            led1_q <= 1'b1;
          end else begin
            fail_cnt <= fail_cnt + 1'b1;
            sr       <= '0;
            bit_cnt  <= '0;
`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
            prefix   <= '0;
`endif
            if (fail_cnt + 1'b1 == FAILS_MAX) begin
              state      <= LOCKED;
              lock_timer <= LOCK_LOAD;
              led2_q     <= 1'b1;
            end else begin
              state <= SHIFTING;
            end
          end
        end

        UNLOCKED: begin
          // Sticky until reset. Edges are ignored and bit_cnt stays at
          // KEY_WIDTH.
          led1_q <= 1'b1;
        end

        LOCKED: begin
          // The timer is loaded with LOCK_CYCLES and the lock is released on
          // the cycle it reads 1. led2 is therefore high for exactly
          // LOCK_CYCLES clocks.
          if (lock_timer == LOCK_LAST) begin
            lock_timer <= '0;
            fail_cnt   <= '0;
            state      <= SHIFTING;
            led2_q     <= 1'b0;
          end else begin
            lock_timer <= lock_timer - 1'b1;
          end
        end

        default: begin
          state  <= SHIFTING;
          led1_q <= 1'b0;
          led2_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- registered outputs ----
  assign bus.led1       = led1_q;
  assign bus.led2       = led2_q;
  assign bus.bit_count  = bit_cnt;
  assign bus.fail_count = fail_cnt;
`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
  assign bus.match_prefix = prefix;
`endif

endmodule

// File: tb/tb_serial_key_lock.sv
// tb_serial_key_lock: directed stimulus for serial_key_lock.
//
// A bit-queue model predicts led1, led2, bit_count, fail_count and (with
// SERIAL_KEY_LOCK_PROGRESS_EN) match_prefix, and these are compared on every
// falling clock edge. Hand-computed literal checks pin the latencies and
// counts.
module tb_serial_key_lock;

  localparam int KW    = 64;
  localparam int SYNC  = 2;
  localparam int MAXF  = 3;
  localparam int LOCKC = 100;
  localparam int CW    = 7;
  localparam int FW    = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] key_v = 64'h39C3_ADF0_E798_E1BC;

  int tests = 0;
  int fails = 0;
  int led2_cycles = 0;

  serial_key_lock_if #(.CW(CW), .FW(FW)) bus ();

  serial_key_lock #(
    .KEY_WIDTH  (KW),
    .KEY        (64'h39C3_ADF0_E798_E1BC),
    .SYNC_STAGES(SYNC),
    .MAX_FAILS  (MAXF),
    .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int   due;
    logic b;
  } ev_t;

  localparam int M_SHIFT = 0;
  localparam int M_CHECK = 1;
  localparam int M_UNLK  = 2;
  localparam int M_LOCK  = 3;

  ev_t  pend[$];
  logic m_bits[$];
  int   m_mode  = M_SHIFT;
  int   m_fails = 0;
  int   m_lock  = 0;
  int   cyc     = 0;

  function automatic int prefix_len();
    int  n    = 0;
    bit  same = 1'b1;
    for (int i = 0; i < m_bits.size(); i++) begin
      if (same && (m_bits[i] == key_v[63-i])) n++;
      else same = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      m_bits.delete();
      m_mode  = M_SHIFT;
      m_fails = 0;
      m_lock  = 0;
    end else begin
      logic        have;
      logic        b;
      logic [63:0] v;
      cyc++;
      have = 1'b0;
      b    = 1'b0;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        have = 1'b1;
        b    = pend[0].b;
        void'(pend.pop_front());
      end
      case (m_mode)
        M_SHIFT: if (have) begin
          m_bits.push_back(b);
          if (m_bits.size() == KW) m_mode = M_CHECK;
        end
        M_CHECK: begin
          v = '0;
          foreach (m_bits[i]) v = {v[62:0], m_bits[i]};
          if (v == key_v) m_mode = M_UNLK;
          else begin
            m_fails++;
            m_bits.delete();
            if (m_fails == MAXF) begin
              m_mode = M_LOCK;
              m_lock = LOCKC;
            end else m_mode = M_SHIFT;
          end
        end
        M_LOCK: begin
          m_lock--;
          if (m_lock == 0) begin
            m_mode  = M_SHIFT;
            m_fails = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_led1", int'(bus.led1), int'(m_mode == M_UNLK));
    chk("model_led2", int'(bus.led2), int'(m_mode == M_LOCK));
    chk("model_bit_count", int'(bus.bit_count), m_bits.size());
    chk("model_fail_count", int'(bus.fail_count), m_fails);
`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
    chk("model_match_prefix", int'(bus.match_prefix), prefix_len());
`endif
    if (bus.led2) led2_cycles++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic b);
    bus.d     = b;
    bus.shift = 1'b1;
    pend.push_back('{cyc + SYNC + 1, b});
  endtask

  task automatic pulse(input logic b, input int hi, input int lo);
    raise(b);
    repeat (hi) tick();
    bus.shift = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) pulse(w[i], 3, 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    bus.shift = 1'b0;
    bus.d     = 1'b0;
    repeat (3) tick();
    chk("reset_led1", int'(bus.led1), 0);
    chk("reset_led2", int'(bus.led2), 0);
    chk("reset_bit_count", int'(bus.bit_count), 0);
    chk("reset_fail_count", int'(bus.fail_count), 0);
    reset = 1'b0;
    tick();

    // Correct key. led1 must rise SYNC+2 cycles after the 64th edge.
    for (int i = 63; i >= 1; i--) pulse(key_v[i], 3, 3);
    raise(key_v[0]);
    repeat (3) tick();
    bus.shift = 1'b0;
    chk("key_led1_early", int'(bus.led1), 0);
    tick();
    chk("key_led1_at_latency", int'(bus.led1), 1);
    repeat (3) pulse(1'b1, 3, 3);
    chk("key_led1_sticky", int'(bus.led1), 1);
    chk("key_bit_count", int'(bus.bit_count), 64);
    chk("key_fail_count", int'(bus.fail_count), 0);
    chk("key_led2", int'(bus.led2), 0);
    do_reset();

    // A single wrong bit, then the correct key.
    send_word(key_v ^ 64'h1);
    chk("wrong_led1", int'(bus.led1), 0);
    chk("wrong_fail_count", int'(bus.fail_count), 1);
    chk("wrong_bit_count", int'(bus.bit_count), 0);
    send_word(key_v);
    chk("retry_led1", int'(bus.led1), 1);
    chk("retry_fail_count", int'(bus.fail_count), 1);
    do_reset();

    // Lockout after three all-zero attempts.
    send_word(64'h0);
    send_word(64'h0);
    chk("two_fails", int'(bus.fail_count), 2);
    led2_cycles = 0;
    send_word(64'h0);
    chk("lock_led2_up", int'(bus.led2), 1);
    chk("lock_fail_count", int'(bus.fail_count), 3);
    repeat (10) pulse(1'b1, 3, 3);
    chk("lock_edges_ignored", int'(bus.bit_count), 0);
    chk("lock_led2_still", int'(bus.led2), 1);
    n = 0;
    while (bus.led2 && n < 300) begin
      tick();
      n++;
    end
    chk("lock_release_in_bound", int'(n < 300), 1);
    chk("lock_led2_cycles", led2_cycles, LOCKC);
    chk("post_lock_fail_count", int'(bus.fail_count), 0);
    chk("post_lock_bit_count", int'(bus.bit_count), 0);
    send_word(key_v);
    chk("post_lock_unlock", int'(bus.led1), 1);
    do_reset();

    // Async reset mid-attempt, checked before any further clock edge.
    for (int i = 63; i >= 27; i--) pulse(key_v[i], 3, 3);
    chk("mid_bit_count", int'(bus.bit_count), 37);
    #2;
    reset = 1'b1;
    #1;
    chk("async_sr", int'(dut.sr == 64'h0), 1);
    chk("async_bit_count", int'(bus.bit_count), 0);
    chk("async_led1", int'(bus.led1), 0);
    chk("async_led2", int'(bus.led2), 0);
    tick();
    reset = 1'b0;
    send_word(key_v);
    chk("after_async_unlock", int'(bus.led1), 1);
    do_reset();

    // One-cycle pulses are each counted once.
    pulse(1'b1, 1, 2);
    pulse(1'b0, 1, 2);
    pulse(1'b1, 1, 2);
    pulse(1'b1, 1, 2);
    pulse(1'b0, 1, 2);
    repeat (4) tick();
    chk("short_pulse_count", int'(bus.bit_count), 5);
    do_reset();

    // d switches to the new bit on the same cycle shift rises.
    for (int i = 63; i >= 0; i--) begin
      bus.d = ~key_v[i];
      tick();
      pulse(key_v[i], 3, 2);
    end
    repeat (2) tick();
    chk("aligned_d_unlock", int'(bus.led1), 1);
    do_reset();

`ifdef SERIAL_KEY_LOCK_PROGRESS_EN
    // 20 matching bits, one wrong bit, then 43 more bits.
    for (int i = 63; i >= 44; i--) pulse(key_v[i], 3, 3);
    pulse(~key_v[43], 3, 3);
    chk("prefix_after_wrong", int'(bus.match_prefix), 20);
    for (int i = 42; i >= 1; i--) pulse(key_v[i], 3, 3);
    chk("prefix_frozen", int'(bus.match_prefix), 20);
    pulse(key_v[0], 3, 3);
    chk("prefix_cleared", int'(bus.match_prefix), 0);
    chk("prefix_fail_count", int'(bus.fail_count), 1);
    do_reset();
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
